traffic_sensor_conditioner: RTL and testbench

//  Upstream stage of the intersection controller. Takes raw asynchronous lane sensors (4 roads x 3 lanes) and 4 emergency/special inputs.

---
 rtl/traffic_sensor_conditioner_pkg.sv | 28 ++
 rtl/traffic_sensor_conditioner_if.sv | 27 ++
 rtl/traffic_sensor_conditioner_debounce.sv | 58 +++++
 rtl/traffic_sensor_conditioner.sv | 127 ++++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared constants and helpers for the traffic sensor conditioner:
// road/lane geometry, emergency input count, lane popcount and
// lowest-set-bit selection used by the emergency arbiter.
package traffic_sensor_conditioner_pkg;

  localparam int NUM_ROADS = 4;
  localparam int NUM_LANES = 3;
  localparam int NUM_VEH   = NUM_ROADS * NUM_LANES;
  localparam int NUM_SS    = 4;
  localparam int OCC_W     = 2 * NUM_ROADS;

  localparam int ROAD_A = 0;
  localparam int ROAD_B = 3;
  localparam int ROAD_C = 6;
  localparam int ROAD_D = 9;
  localparam int ROAD_OFS [NUM_ROADS] = '{ROAD_A, ROAD_B, ROAD_C, ROAD_D};

  // Number of occupied lanes on one road (0..3).
  function automatic logic [1:0] lane_count(input logic [NUM_LANES-1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Isolate the lowest set bit; bit 0 is the highest-priority emergency.
  function automatic logic [NUM_SS-1:0] lowest_set(input logic [NUM_SS-1:0] v);
    return v & (~v + NUM_SS'(1));
  endfunction

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// Sensor-side bus of the traffic sensor conditioner. The slave modport is
// the conditioner itself; the master modport is whoever drives the raw
// sensors and the controller acknowledge.
interface traffic_sensor_conditioner_if;
  import traffic_sensor_conditioner_pkg::*;

  logic [NUM_VEH-1:0] raw_veh;
  logic [NUM_SS-1:0]  raw_ss;
  logic               ss_ack;
  logic [NUM_VEH-1:0] veh;
  logic [OCC_W-1:0]   occ;
  logic               veh_change;
  logic [NUM_SS-1:0]  ss_req;
  logic [NUM_SS-1:0]  ss_pending;
  logic [NUM_VEH-1:0] stuck_flag;

  modport slave (
    input  raw_veh, raw_ss, ss_ack,
    output veh, occ, veh_change, ss_req, ss_pending, stuck_flag
  );

  modport master (
    output raw_veh, raw_ss, ss_ack,
    input  veh, occ, veh_change, ss_req, ss_pending, stuck_flag
  );

endinterface

// File: rtl/traffic_sensor_conditioner_debounce.sv
// sensor_debounce: one raw asynchronous input -> SYNC_STAGES-flop
// synchroniser -> counter-based debouncer. Exposes both the current
// debounced bit and its next-cycle value so the parent can register
// derived state (occupancy, change pulse) in the same cycle.
module sensor_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 3
) (
  input  logic clock,
  input  logic clear,
  input  logic raw_i,
  output logic db_o,
  output logic db_nxt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [DB_W-1:0]        cnt_q, cnt_d;
  logic                   db_q, db_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchroniser shift chain; bit 0 samples the raw pin.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  // Count consecutive mismatch cycles; toggle once the mismatch has lasted DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync_out == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_d  = ~db_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  // Debounce state register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_o     = db_q;
  assign db_nxt_o = db_d;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: debounces 12 lane sensors and 4 emergency
// inputs, produces per-road occupancy, a veh change pulse, and a held
// one-hot emergency request with a pending queue.
// Optional feature macro: SENSOR_STUCK_DET_EN (per-lane stuck-high masking).
module traffic_sensor_conditioner
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 3,
  parameter int STUCK_CYCLES    = 1024,
  parameter int STUCK_W         = 11
) (
  input  logic                        clock,
  input  logic                        clear,
  traffic_sensor_conditioner_if.slave bus
);

  logic [NUM_VEH-1:0] vdb_q, vdb_d;
  logic [NUM_SS-1:0]  sdb_q, sdb_d;
  logic [NUM_VEH-1:0] stuck_q, stuck_d;
  logic [NUM_VEH-1:0] veh_cur, veh_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               veh_change_q;
  logic [NUM_SS-1:0]  ss_req_q, ss_req_d;
  logic [NUM_SS-1:0]  ss_pend_q, ss_pend_d;
  logic [NUM_SS-1:0]  ss_rise, ss_grant;

  for (genvar i = 0; i < NUM_VEH; i++) begin : g_veh_db
    sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W))
      u_db (.clock(clock), .clear(clear), .raw_i(bus.raw_veh[i]), .db_o(vdb_q[i]), .db_nxt_o(vdb_d[i]));
  end

  for (genvar k = 0; k < NUM_SS; k++) begin : g_ss_db
    sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W))
      u_db (.clock(clock), .clear(clear), .raw_i(bus.raw_ss[k]), .db_o(sdb_q[k]), .db_nxt_o(sdb_d[k]));
  end

`ifdef SENSOR_STUCK_DET_EN
  logic [STUCK_W-1:0] stk_cnt_q [NUM_VEH];
  logic [STUCK_W-1:0] stk_cnt_d [NUM_VEH];

  // Count consecutive debounced-high cycles; flag once STUCK_CYCLES have elapsed.
  always_comb begin
    for (int i = 0; i < NUM_VEH; i++) begin
      stk_cnt_d[i] = '0;
      stuck_d[i]   = 1'b0;
      if (vdb_d[i]) begin
        stuck_d[i]   = (stk_cnt_q[i] == STUCK_W'(STUCK_CYCLES));
        stk_cnt_d[i] = stuck_d[i] ? stk_cnt_q[i] : stk_cnt_q[i] + STUCK_W'(1);
      end
    end
  end

  // Stuck counters and flags.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_VEH; i++) stk_cnt_q[i] <= '0;
      stuck_q <= '0;
    end else begin
      for (int i = 0; i < NUM_VEH; i++) stk_cnt_q[i] <= stk_cnt_d[i];
      stuck_q <= stuck_d;
    end
  end
`else
  assign stuck_d = '0;
  assign stuck_q = '0;
`endif

  assign veh_cur = vdb_q & ~stuck_q;
  assign veh_d   = vdb_d & ~stuck_d;

  // Occupancy is computed from next-cycle veh so it lines up with veh.
  always_comb begin
    occ_d = '0;
    for (int r = 0; r < NUM_ROADS; r++)
      occ_d[2*r +: 2] = lane_count(veh_d[ROAD_OFS[r] +: NUM_LANES]);
  end

  // Occupancy and change-pulse registers.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      occ_q        <= '0;
      veh_change_q <= 1'b0;
    end else begin
      occ_q        <= occ_d;
      veh_change_q <= (veh_d != veh_cur);
    end
  end

  // Emergency arbiter: rises queue in pending (held bit absorbed); an idle
  // request slot takes the lowest pending bit; ack frees the slot.
  always_comb begin
    ss_rise   = sdb_d & ~sdb_q;
    ss_grant  = '0;
    ss_req_d  = ss_req_q;
    ss_pend_d = ss_pend_q | (ss_rise & ~ss_req_q);
    if (ss_req_q == '0) begin
      if (ss_pend_q != '0) begin
        ss_grant  = lowest_set(ss_pend_q);
        ss_req_d  = ss_grant;
        ss_pend_d = ss_pend_d & ~ss_grant;
      end
    end else if (bus.ss_ack) begin
      ss_req_d = '0;
    end
  end

  // Arbiter state.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ss_req_q  <= '0;
      ss_pend_q <= '0;
    end else begin
      ss_req_q  <= ss_req_d;
      ss_pend_q <= ss_pend_d;
    end
  end

  assign bus.veh        = veh_cur;
  assign bus.occ        = occ_q;
  assign bus.veh_change = veh_change_q;
  assign bus.ss_req     = ss_req_q;
  assign bus.ss_pending = ss_pend_q;
  assign bus.stuck_flag = stuck_q;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner: reset, debounce latency
// and glitch filtering, occupancy, emergency arbitration, ack collision,
// stuck-lane behaviour (SENSOR_STUCK_DET_EN aware) and async reset.
module tb_traffic_sensor_conditioner;

  logic clock;
  logic clear;
  int   n_checks;
  int   n_errors;

  traffic_sensor_conditioner_if bus ();

  traffic_sensor_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .DB_W(3), .STUCK_CYCLES(16), .STUCK_W(5)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic ack_pulse();
    bus.ss_ack = 1'b1;
    tick(1);
    bus.ss_ack = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    clear       = 1'b0;
    bus.raw_veh = 12'hFFF;
    bus.raw_ss  = 4'hF;
    bus.ss_ack  = 1'b0;

    // 1. reset with all inputs high
    tick(3);
    chk("rst_veh",   32'(bus.veh), 32'h0);
    chk("rst_occ",   32'(bus.occ), 32'h0);
    chk("rst_chg",   32'(bus.veh_change), 32'h0);
    chk("rst_req",   32'(bus.ss_req), 32'h0);
    chk("rst_pend",  32'(bus.ss_pending), 32'h0);
    chk("rst_stuck", 32'(bus.stuck_flag), 32'h0);
    clear = 1'b1;
    tick(5);
    chk("lat5_veh",  32'(bus.veh), 32'h0);
    tick(1);
    chk("lat6_veh",  32'(bus.veh), 32'hFFF);
    chk("lat6_occ",  32'(bus.occ), 32'hFF);
    chk("lat6_chg",  32'(bus.veh_change), 32'h1);
    chk("lat6_pend", 32'(bus.ss_pending), 32'hF);
    chk("lat6_req",  32'(bus.ss_req), 32'h0);
    tick(1);
    chk("lat7_chg",  32'(bus.veh_change), 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_req%0d", k), 32'(bus.ss_req), 32'(1 << k));
      chk($sformatf("drain_pend%0d", k), 32'(bus.ss_pending), 32'((4'hF << (k + 1)) & 4'hF));
      ack_pulse();
      chk($sformatf("drain_ack%0d", k), 32'(bus.ss_req), 32'h0);
      tick(1);
    end
    tick(3);
    chk("held_noreq", 32'(bus.ss_req), 32'h0);
    chk("held_nopend", 32'(bus.ss_pending), 32'h0);
    bus.raw_veh = '0;
    bus.raw_ss  = '0;
    tick(12);
    chk("idle_veh", 32'(bus.veh), 32'h0);

    // 2. glitch filtering and debounce latency
    bus.raw_veh = 12'h001;
    tick(3);
    bus.raw_veh = 12'h000;
    tick(10);
    chk("glitch3_veh", 32'(bus.veh), 32'h0);
    bus.raw_veh = 12'h001;
    tick(4);
    bus.raw_veh = 12'h000;
    tick(1);
    chk("pulse4_e5", 32'(bus.veh), 32'h0);
    tick(1);
    chk("pulse4_e6", 32'(bus.veh), 32'h1);
    tick(10);
    chk("pulse4_end", 32'(bus.veh), 32'h0);

    // 3. occupancy
    bus.raw_veh = 12'b011_000_001_111;
    tick(6);
    chk("occ1_veh", 32'(bus.veh), 32'b011_000_001_111);
    chk("occ1_occ", 32'(bus.occ), 32'b10_00_01_11);
    bus.raw_veh = 12'b111_110_100_000;
    tick(6);
    chk("occ2_occ", 32'(bus.occ), 32'b11_10_01_00);
    bus.raw_veh = '0;
    tick(8);
    chk("occ0_occ", 32'(bus.occ), 32'h0);

    // 4. arbitration
    bus.raw_ss = 4'b1100;
    tick(6);
    chk("arb_pend0", 32'(bus.ss_pending), 32'b1100);
    tick(1);
    chk("arb_req1",  32'(bus.ss_req), 32'b0100);
    chk("arb_pend1", 32'(bus.ss_pending), 32'b1000);
    ack_pulse();
    chk("arb_ack1",  32'(bus.ss_req), 32'b0000);
    tick(1);
    chk("arb_req2",  32'(bus.ss_req), 32'b1000);
    chk("arb_pend2", 32'(bus.ss_pending), 32'b0000);
    ack_pulse();
    chk("arb_ack2",  32'(bus.ss_req), 32'b0000);
    ack_pulse();
    tick(1);
    chk("arb_idle_ack", 32'(bus.ss_req), 32'b0000);
    bus.raw_ss = '0;
    tick(10);

    // 5. rise colliding with ack
    bus.raw_ss = 4'b0010;
    tick(7);
    chk("col_req", 32'(bus.ss_req), 32'b0010);
    bus.raw_ss = 4'b0011;
    tick(5);
    bus.ss_ack = 1'b1;
    tick(1);
    bus.ss_ack = 1'b0;
    chk("col_ack_req",  32'(bus.ss_req), 32'b0000);
    chk("col_ack_pend", 32'(bus.ss_pending), 32'b0001);
    tick(1);
    chk("col_next_req", 32'(bus.ss_req), 32'b0001);
    ack_pulse();
    bus.raw_ss = '0;
    tick(10);

    // 6. stuck lane
    bus.raw_veh = 12'h020;
    tick(6);
    chk("stk_rise", 32'(bus.veh), 32'h020);
    tick(15);
    chk("stk_15_veh", 32'(bus.veh), 32'h020);
    chk("stk_15_flag", 32'(bus.stuck_flag), 32'h0);
    tick(1);
`ifdef SENSOR_STUCK_DET_EN
    chk("stk_16_flag", 32'(bus.stuck_flag), 32'h020);
    chk("stk_16_veh",  32'(bus.veh), 32'h0);
    chk("stk_16_chg",  32'(bus.veh_change), 32'h1);
    bus.raw_veh = '0;
    tick(5);
    chk("stk_hold_flag", 32'(bus.stuck_flag), 32'h020);
    tick(1);
    chk("stk_clr_flag", 32'(bus.stuck_flag), 32'h0);
`else
    chk("stk_16_flag", 32'(bus.stuck_flag), 32'h0);
    chk("stk_16_veh",  32'(bus.veh), 32'h020);
    bus.raw_veh = '0;
    tick(6);
    chk("stk_drop_veh", 32'(bus.veh), 32'h0);
`endif
    tick(4);

    // 7. async reset during a held request
    bus.raw_ss = 4'b1000;
    tick(7);
    chk("ar_req", 32'(bus.ss_req), 32'b1000);
    clear = 1'b0;
    #1;
    chk("ar_req_clr",  32'(bus.ss_req), 32'h0);
    chk("ar_pend_clr", 32'(bus.ss_pending), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
